output_buffer_sequencer: RTL and testbench

Per-stream consumer of the memory-configuration buffer queue. It sits at the front of the OutputWriter. It pops host-enqueued buffer descriptors and maps upstream write requests onto them as bounded write commands. It reports each filled or closed buffer back to the host-notification path, and honours the host flush pulse by discarding stale descriptors. One instance is used per stream.

---
 rtl/output_buffer_sequencer.sv | 137 +++++++++++++
 tb/tb_output_buffer_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer_sequencer.sv
// output_buffer_sequencer: maps write requests onto host buffer descriptors as bounded write commands
// Optional OUTPUT_BUF_STATS_EN adds the stat_buffers/stat_bytes counters.
module output_buffer_sequencer #(
    parameter int VADDR_BITS     = 48,
    parameter int LEN_BITS       = 28,
    parameter int MAX_XFER_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  buf_valid,
    output logic                  buf_ready,
    input  logic [VADDR_BITS-1:0] buf_vaddr,
    input  logic [LEN_BITS-1:0]   buf_size,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LEN_BITS-1:0]   req_len,
    input  logic                  req_last,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [VADDR_BITS-1:0] cmd_vaddr,
    output logic [LEN_BITS-1:0]   cmd_len,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [VADDR_BITS-1:0] done_vaddr,
    output logic [LEN_BITS-1:0]   done_bytes,
    output logic                  done_end
`ifdef OUTPUT_BUF_STATS_EN
    ,
    output logic [31:0]           stat_buffers,
    output logic [63:0]           stat_bytes
`endif
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, COMPLETE, FLUSH} state_t;
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_XFER_BYTES);

    state_t state, state_nxt;
    logic cur_vld, req_lst, flush_pend;
    logic [VADDR_BITS-1:0] cur_base;
    logic [LEN_BITS-1:0] cur_size, cur_off, req_rem, buf_left, xfer_a, xfer, new_off, new_rem;

    assign buf_left = cur_size - cur_off;
    assign xfer_a   = req_rem < buf_left ? req_rem : buf_left;
    assign xfer     = xfer_a < MAX_LEN ? xfer_a : MAX_LEN;
    assign new_off  = cur_off + xfer;
    assign new_rem  = req_rem - xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        buf_ready  = 1'b0;
        req_ready  = 1'b0;
        cmd_valid  = 1'b0;
        done_valid = 1'b0;
        case (state)
            IDLE: begin
                // rst_n gating keeps req_ready low while reset is held
                req_ready = rst_n && !flush_pend && !flush;
                if (flush || flush_pend) state_nxt = FLUSH;
                else if (req_valid)
                    state_nxt = req_len != '0 ? (cur_vld ? ISSUE : LOAD) : (req_last ? COMPLETE : IDLE);
            end
            LOAD: begin
                buf_ready = 1'b1;
                if (buf_valid && buf_size != '0) state_nxt = ISSUE;
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready)
                    state_nxt = (new_off == cur_size || (new_rem == '0 && req_lst)) ? COMPLETE :
                                new_rem == '0 ? IDLE : ISSUE;
            end
            COMPLETE: begin
                done_valid = 1'b1;
                if (done_ready) state_nxt = req_rem != '0 ? LOAD : IDLE;
            end
            FLUSH: begin
                buf_ready = 1'b1;
                if (!buf_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_vaddr  = cmd_valid ? cur_base + VADDR_BITS'(cur_off) : '0;
    assign cmd_len    = cmd_valid ? xfer : '0;
    assign done_vaddr = done_valid && cur_vld ? cur_base : '0;
    assign done_bytes = done_valid && cur_vld ? cur_off : '0;
    assign done_end   = done_valid && req_lst && req_rem == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_vld    <= 1'b0;
            cur_base   <= '0;
            cur_size   <= '0;
            cur_off    <= '0;
            req_rem    <= '0;
            req_lst    <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                req_rem <= req_len;
                req_lst <= req_last;
            end
            if (state == LOAD && buf_valid && buf_size != '0) begin
                cur_base <= buf_vaddr;
                cur_size <= buf_size;
                cur_off  <= '0;
                cur_vld  <= 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                cur_off <= new_off;
                req_rem <= new_rem;
            end
            if (state == FLUSH || (done_valid && done_ready)) cur_vld <= 1'b0;
            // a flush seen mid-transfer waits until the block is back in IDLE
            if (state == FLUSH) flush_pend <= 1'b0;
            else if (flush && state != IDLE) flush_pend <= 1'b1;
        end
    end

`ifdef OUTPUT_BUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_buffers <= '0;
            stat_bytes   <= '0;
        end else begin
            if (done_valid && done_ready && done_bytes != '0) stat_buffers <= stat_buffers + 32'd1;
            if (cmd_valid && cmd_ready) stat_bytes <= stat_bytes + 64'(cmd_len);
        end
    end
`endif
endmodule

// File: tb/tb_output_buffer_sequencer.sv
// tb_output_buffer_sequencer: randomized scoreboard bench for output_buffer_sequencer
// Optional OUTPUT_BUF_STATS_EN only changes the port connections.
module tb_output_buffer_sequencer;
    localparam int MX = 4096;

    logic clk = 1'b0, rst_n = 1'b0;
    logic buf_valid = 1'b0, buf_ready;
    logic [47:0] buf_vaddr = '0;
    logic [27:0] buf_size = '0;
    logic flush = 1'b0;
    logic req_valid = 1'b0, req_ready, req_last = 1'b0;
    logic [27:0] req_len = '0;
    logic cmd_valid, cmd_ready = 1'b0;
    logic [47:0] cmd_vaddr;
    logic [27:0] cmd_len;
    logic done_valid, done_ready = 1'b0, done_end;
    logic [47:0] done_vaddr;
    logic [27:0] done_bytes;
`ifdef OUTPUT_BUF_STATS_EN
    logic [31:0] stat_buffers;
    logic [63:0] stat_bytes;
`endif

    output_buffer_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .buf_valid(buf_valid), .buf_ready(buf_ready), .buf_vaddr(buf_vaddr), .buf_size(buf_size),
        .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_last(req_last),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vaddr(cmd_vaddr), .cmd_len(cmd_len),
        .done_valid(done_valid), .done_ready(done_ready), .done_vaddr(done_vaddr),
        .done_bytes(done_bytes), .done_end(done_end)
`ifdef OUTPUT_BUF_STATS_EN
        , .stat_buffers(stat_buffers), .stat_bytes(stat_bytes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [47:0] a; logic [27:0] l;} item_t;
    typedef struct packed {logic [47:0] a; logic [27:0] l; logic e;} done_t;

    item_t desc_q[$], mdesc[$], exp_cmd[$];
    done_t exp_done[$];
    int vectors = 0, miscompares = 0, pops = 0;
    bit hold_cmd = 1'b0;
    logic m_vld = 1'b0;
    logic [47:0] m_base = '0;
    logic [27:0] m_size = '0, m_off = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic enq(logic [47:0] a, logic [27:0] s);
        desc_q.push_back({a, s});
        mdesc.push_back({a, s});
    endtask

    // Reference: walk the request across buffers in whole chunks
    task automatic model_req(logic [27:0] len, bit last);
        logic [27:0] rem, chunk;
        item_t d;
        rem = len;
        if (len == 0) begin
            if (last) begin
                exp_done.push_back({m_vld ? m_base : 48'h0, m_vld ? m_off : 28'h0, 1'b1});
                m_vld = 1'b0;
            end
            return;
        end
        while (rem != 0) begin
            if (!m_vld) begin
                while (mdesc.size() > 0 && mdesc[0].l == 0) void'(mdesc.pop_front());
                if (mdesc.size() == 0) begin
                    miscompares++;
                    $display("FAIL model: no descriptor available");
                    return;
                end
                d = mdesc.pop_front();
                m_base = d.a; m_size = d.l; m_off = 0; m_vld = 1'b1;
            end
            chunk = rem;
            if (m_size - m_off < chunk) chunk = m_size - m_off;
            if (28'(MX) < chunk) chunk = 28'(MX);
            exp_cmd.push_back({m_base + 48'(m_off), chunk});
            m_off += chunk;
            rem -= chunk;
            if (m_off == m_size || (rem == 0 && last)) begin
                exp_done.push_back({m_base, m_off, rem == 0 && last});
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic send_req(logic [27:0] len, bit last);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_len = len; req_last = last;
        #1;
        while (!req_ready && n < 5000) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            miscompares++;
            $display("FAIL req_timeout: req_ready never rose");
        end else model_req(len, last);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        m_vld = 1'b0;
        mdesc.delete();
    endtask

    task automatic wait_quiet(string nm);
        int n = 0;
        do begin
            @(negedge clk); #3; n++;
        end while (!(exp_cmd.size() == 0 && exp_done.size() == 0 && req_ready) && n < 5000);
        if (n >= 5000) begin
            miscompares++;
            $display("FAIL %s: timeout waiting for idle, cmd_q=%0d done_q=%0d", nm, exp_cmd.size(), exp_done.size());
        end
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_cmd_valid"}, 64'(cmd_valid), 0);
        chk({nm, "_cmd_vaddr"}, 64'(cmd_vaddr), 0);
        chk({nm, "_cmd_len"}, 64'(cmd_len), 0);
        chk({nm, "_done_valid"}, 64'(done_valid), 0);
        chk({nm, "_done_fields"}, 64'({done_vaddr, done_end}) | 64'(done_bytes), 0);
        chk({nm, "_buf_ready"}, 64'(buf_ready), 0);
        chk({nm, "_req_ready"}, 64'(req_ready), 0);
    endtask

    // Descriptor FIFO and sink backpressure
    initial forever begin
        @(negedge clk);
        buf_valid = desc_q.size() > 0;
        if (buf_valid) begin
            buf_vaddr = desc_q[0].a;
            buf_size  = desc_q[0].l;
        end
        cmd_ready  = !hold_cmd && $urandom_range(0, 3) != 0;
        done_ready = $urandom_range(0, 3) != 0;
        #1;
        if (buf_valid && buf_ready && desc_q.size() > 0) begin
            void'(desc_q.pop_front());
            pops++;
        end
    end

    // Monitor: compares every cmd/done handshake against the scoreboard
    item_t   mc;
    done_t   md;
    bit      cstall = 1'b0, dstall = 1'b0;
    item_t   cprev;
    done_t   dprev;
    initial forever begin
        @(negedge clk); #2;
        if (!rst_n) begin
            cstall = 1'b0; dstall = 1'b0;
        end else begin
            if (int'(cmd_valid) + int'(done_valid) + int'(buf_ready) > 1) begin
                miscompares++;
                $display("FAIL onehot: cmd_valid=%0b done_valid=%0b buf_ready=%0b", cmd_valid, done_valid, buf_ready);
            end
            if (cstall) begin
                chk("cmd_hold_valid", 64'(cmd_valid), 1);
                chk("cmd_hold_data", 64'({cmd_vaddr, cmd_len} ^ cprev), 0);
            end
            if (dstall) begin
                chk("done_hold_valid", 64'(done_valid), 1);
                chk("done_hold_data", 64'({done_vaddr, done_bytes, done_end} ^ dprev), 0);
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    miscompares++;
                    $display("FAIL cmd_unexpected: vaddr=0x%0h len=%0d", cmd_vaddr, cmd_len);
                end else begin
                    mc = exp_cmd.pop_front();
                    chk("cmd_vaddr", 64'(cmd_vaddr), 64'(mc.a));
                    chk("cmd_len", 64'(cmd_len), 64'(mc.l));
                end
            end
            if (done_valid && done_ready) begin
                if (exp_done.size() == 0) begin
                    miscompares++;
                    $display("FAIL done_unexpected: vaddr=0x%0h bytes=%0d", done_vaddr, done_bytes);
                end else begin
                    md = exp_done.pop_front();
                    chk("done_vaddr", 64'(done_vaddr), 64'(md.a));
                    chk("done_bytes", 64'(done_bytes), 64'(md.l));
                    chk("done_end", 64'(done_end), 64'(md.e));
                end
            end
            cstall = cmd_valid && !cmd_ready;
            dstall = done_valid && !done_ready;
            cprev  = {cmd_vaddr, cmd_len};
            dprev  = {done_vaddr, done_bytes, done_end};
        end
    end

    initial begin
        #900000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int p0, n;
        logic [27:0] len;
        bit last;
        longint cap;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 6000 bytes into one 8 KiB buffer, loaded on demand
        wait_quiet("t1_pre");
        enq(48'h1000, 28'd8192);
        send_req(28'd6000, 1'b1);
        #1 chk("t1_load_lat_c1", 64'(cmd_valid), 0);
        @(negedge clk);
        #1 chk("t1_load_lat_c2", 64'(cmd_valid), 1);
        wait_quiet("t1");

        // split across A and B, then close B with a zero-length last
        enq(48'h10000, 28'd1024);
        enq(48'h20000, 28'd4096);
        send_req(28'd3000, 1'b0);
        wait_quiet("t2a");
        send_req(28'd0, 1'b1);
        wait_quiet("t2b");
        enq(48'h40000, 28'd4096);
        send_req(28'd100, 1'b0);
        wait_quiet("t2c");
        send_req(28'd50, 1'b0);
        #1 chk("held_lat_c1", 64'(cmd_valid), 1);
        wait_quiet("t2d");

        // flush in IDLE with three queued descriptors
        enq(48'h100000, 28'd512);
        enq(48'h200000, 28'd0);
        enq(48'h300000, 28'd2048);
        p0 = pops;
        pulse_flush();
        wait_quiet("t3");
        chk("t3_flush_pops", 64'(pops - p0), 3);
        chk("t3_queue_left", 64'(desc_q.size()), 0);
        enq(48'h5000, 28'd256);
        send_req(28'd256, 1'b1);
        wait_quiet("t3b");

        // flush while a command is stalled
        hold_cmd = 1'b1;
        enq(48'h8000, 28'd16384);
        enq(48'h9000, 28'd64);
        send_req(28'd10000, 1'b1);
        @(negedge clk);
        #1;
        chk("t4_cmd_valid", 64'(cmd_valid), 1);
        chk("t4_cmd_vaddr", 64'(cmd_vaddr), 64'h8000);
        chk("t4_cmd_len", 64'(cmd_len), 4096);
        pulse_flush();
        repeat (3) @(negedge clk);
        hold_cmd = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #3; n++;
        end while (!req_ready && n < 5000);
        chk("t4_ready_after_flush", 64'(req_ready), 1);
        chk("t4_pending_at_ready", 64'(exp_cmd.size() + exp_done.size() + desc_q.size()), 0);

        // zero-size descriptor is skipped
        enq(48'h2F00, 28'd0);
        enq(48'h3000, 28'd64);
        send_req(28'd64, 1'b1);
        wait_quiet("t5");
        chk("t5_queue_left", 64'(desc_q.size()), 0);

        // async reset during ISSUE
        hold_cmd = 1'b1;
        enq(48'hA000, 28'd8192);
        send_req(28'd8000, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        exp_cmd.delete(); exp_done.delete(); desc_q.delete(); mdesc.delete();
        m_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold_cmd = 1'b0;
        enq(48'hB000, 28'd128);
        send_req(28'd128, 1'b1);
        #1 chk("t6_load_lat_c1", 64'(cmd_valid), 0);
        @(negedge clk);
        #1 chk("t6_load_lat_c2", 64'(cmd_valid), 1);
        wait_quiet("t6");

        // randomized mix
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1: enq($urandom_range(0, 7) == 0 ? 48'hFFFF_FFFF_F800 : {16'($urandom), 32'($urandom)},
                          $urandom_range(0, 9) == 0 ? 28'd0 : 28'($urandom_range(1, 9000)));
                9: begin
                    pulse_flush();
                    wait_quiet("rnd_flush");
                end
                default: begin
                    len  = $urandom_range(0, 4) == 0 ? 28'd0 : 28'($urandom_range(1, 12000));
                    last = $urandom_range(0, 2) == 0;
                    cap  = m_vld ? longint'(m_size - m_off) : 0;
                    foreach (mdesc[k]) cap += longint'(mdesc[k].l);
                    if (longint'(len) > cap)
                        enq({16'($urandom), 32'($urandom)}, 28'(longint'(len) - cap + longint'($urandom_range(0, 3000))));
                    send_req(len, last);
                    if ($urandom_range(0, 1) == 0) wait_quiet("rnd_req");
                end
            endcase
        end
        wait_quiet("final");
        chk("final_cmd_left", 64'(exp_cmd.size()), 0);
        chk("final_done_left", 64'(exp_done.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
